// File: rtl/lfsr_prbs_chk.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : lfsr_prbs_chk
// Purpose  : Self-synchronising PRBS checker. Each received word is predicted
//            from the previously received bits using the generator
//            polynomial. Mismatching bits are flagged, and lock is tracked
//            with a SEARCH/LOCKED state machine. A saturating bit-error total
//            is kept while locked.
// Ports    : clk        - clock
//            rst_n      - asynchronous active-low reset
//            enable     - data_in valid this cycle
//            data_in    - received PRBS word (DATA_WIDTH)
//            clear      - synchronous clear of err_count / word_count
//            err_out    - per-bit mismatch of the last checked word
//            err_valid  - one-cycle pulse, err_out refreshed
//            locked     - checker is locked to the stream
//            err_count  - saturating bit-error total while locked
//            word_count - words checked while locked (32 bit)
// Options  : define LFSR_PRBS_CHK_WORD_CNT_EN to implement the word_count
//            register. Without it, word_count is tied to zero and the port
//            list does not change.
// Revision : 1.0 - initial release
// ============================================================================
module lfsr_prbs_chk #(
    parameter int                    LFSR_WIDTH    = 31,
    parameter logic [LFSR_WIDTH-1:0] LFSR_POLY     = 31'h10000001,
    parameter string                 LFSR_CONFIG   = "FIBONACCI",
    parameter int                    REVERSE       = 0,
    parameter int                    INVERT        = 1,
    parameter int                    DATA_WIDTH    = 8,
    parameter int                    LOCK_COUNT    = 16,
    parameter int                    UNLOCK_COUNT  = 4,
    parameter int                    ERR_CNT_WIDTH = 32
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     enable,
    input  logic [DATA_WIDTH-1:0]    data_in,
    input  logic                     clear,
    output logic [DATA_WIDTH-1:0]    err_out,
    output logic                     err_valid,
    output logic                     locked,
    output logic [ERR_CNT_WIDTH-1:0] err_count,
    output logic [31:0]              word_count
);

    localparam int c_good_w = $clog2(LOCK_COUNT + 1);
    localparam int c_bad_w  = $clog2(UNLOCK_COUNT + 1);
    localparam int c_pop_w  = $clog2(DATA_WIDTH + 1);

    localparam logic [c_good_w-1:0] c_lock_limit   = c_good_w'(LOCK_COUNT);
    localparam logic [c_bad_w-1:0]  c_unlock_limit = c_bad_w'(UNLOCK_COUNT);

    typedef enum logic [0:0] {
        ST_SEARCH = 1'b0,
        ST_LOCKED = 1'b1
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t                   r_state;
    logic [LFSR_WIDTH-1:0]    r_history;
    logic [c_good_w-1:0]      r_good_cnt;
    logic [c_bad_w-1:0]       r_bad_cnt;
    logic [DATA_WIDTH-1:0]    r_err_out;
    logic                     r_err_valid;
    logic                     r_locked;
    logic [ERR_CNT_WIDTH-1:0] r_err_count;

    // ------------------------------------------------------------------------
    // Combinational datapath
    // ------------------------------------------------------------------------
    logic [DATA_WIDTH-1:0]    w_din_inv;      // inversion undone
    logic [DATA_WIDTH-1:0]    w_din_ord;      // in processing order (MSB first)
    logic [DATA_WIDTH-1:0]    w_mis_ord;      // mismatch in processing order
    logic [DATA_WIDTH-1:0]    w_mismatch;     // mismatch in data_in bit order
    logic [LFSR_WIDTH-1:0]    w_history_next;
    logic                     w_word_err;
    logic [c_pop_w-1:0]       w_popcnt;
    logic [ERR_CNT_WIDTH:0]   w_err_sum;
    logic [ERR_CNT_WIDTH-1:0] w_err_sat;
    logic                     w_count_en;

    generate
        if (INVERT != 0) begin : g_inv
            assign w_din_inv = ~data_in;
        end else begin : g_noinv
            assign w_din_inv = data_in;
        end
    endgenerate

    // The core always shifts the word MSB first. With an LSB-first line the
    // word is mirrored on the way in, and the mismatch is mirrored back so
    // err_out bit i always refers to data_in bit i.
    generate
        if (REVERSE != 0) begin : g_rev
            for (genvar i = 0; i < DATA_WIDTH; i++) begin : g_bit
                assign w_din_ord[i]  = w_din_inv[DATA_WIDTH-1-i];
                assign w_mismatch[i] = w_mis_ord[DATA_WIDTH-1-i];
            end
        end else begin : g_norev
            assign w_din_ord  = w_din_inv;
            assign w_mismatch = w_mis_ord;
        end
    endgenerate

    // Feed-forward LFSR: the register only ever holds received bits, so a
    // line error is flushed out after LFSR_WIDTH bits instead of
    // recirculating. The output of each step is received XOR predicted.
    generate
        if (LFSR_CONFIG == "GALOIS") begin : g_galois
            always_comb begin
                logic [LFSR_WIDTH-1:0] w_s;
                w_s       = r_history;
                w_mis_ord = '0;
                for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
                    w_mis_ord[i] = w_s[LFSR_WIDTH-1] ^ w_din_ord[i];
                    w_s          = {w_s[LFSR_WIDTH-2:0], w_din_ord[i]};
                    for (int j = 1; j < LFSR_WIDTH; j++) begin
                        if (LFSR_POLY[j]) begin
                            w_s[j] = w_s[j] ^ w_din_ord[i];
                        end
                    end
                end
                w_history_next = w_s;
            end
        end else begin : g_fibonacci
            always_comb begin
                logic [LFSR_WIDTH-1:0] w_s;
                logic                  w_fb;
                w_s       = r_history;
                w_mis_ord = '0;
                for (int i = DATA_WIDTH - 1; i >= 0; i--) begin
                    w_fb = w_s[LFSR_WIDTH-1];
                    for (int j = 1; j < LFSR_WIDTH; j++) begin
                        if (LFSR_POLY[j]) begin
                            w_fb = w_fb ^ w_s[j-1];
                        end
                    end
                    w_mis_ord[i] = w_fb ^ w_din_ord[i];
                    w_s          = {w_s[LFSR_WIDTH-2:0], w_din_ord[i]};
                end
                w_history_next = w_s;
            end
        end
    endgenerate

    always_comb begin
        w_popcnt = '0;
        for (int i = 0; i < DATA_WIDTH; i++) begin
            w_popcnt = w_popcnt + c_pop_w'(w_mismatch[i]);
        end
    end

    assign w_word_err = |w_mismatch;
    assign w_count_en = enable && (r_state == ST_LOCKED);

    // One extra bit catches the carry; on overflow the total pins at all-ones.
    assign w_err_sum = {1'b0, r_err_count} + (ERR_CNT_WIDTH + 1)'(w_popcnt);
    assign w_err_sat = w_err_sum[ERR_CNT_WIDTH] ? {ERR_CNT_WIDTH{1'b1}}
                                                : w_err_sum[ERR_CNT_WIDTH-1:0];

    // ------------------------------------------------------------------------
    // History, lock state machine and error total
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_SEARCH;
            r_history   <= '0;
            r_good_cnt  <= '0;
            r_bad_cnt   <= '0;
            r_err_out   <= '0;
            r_err_valid <= 1'b0;
            r_locked    <= 1'b0;
            r_err_count <= '0;
        end else begin
            r_err_valid <= enable;

            if (enable) begin
                r_history <= w_history_next;
                r_err_out <= w_mismatch;

                case (r_state)
                    ST_SEARCH: begin
                        if (w_word_err) begin
                            r_good_cnt <= '0;
                        end else if (r_good_cnt + c_good_w'(1) == c_lock_limit) begin
                            r_state    <= ST_LOCKED;
                            r_locked   <= 1'b1;
                            r_good_cnt <= '0;
                            r_bad_cnt  <= '0;
                        end else begin
                            r_good_cnt <= r_good_cnt + c_good_w'(1);
                        end
                    end
                    ST_LOCKED: begin
                        if (!w_word_err) begin
                            r_bad_cnt <= '0;
                        end else if (r_bad_cnt + c_bad_w'(1) == c_unlock_limit) begin
                            r_state    <= ST_SEARCH;
                            r_locked   <= 1'b0;
                            r_good_cnt <= '0;
                            r_bad_cnt  <= '0;
                        end else begin
                            r_bad_cnt <= r_bad_cnt + c_bad_w'(1);
                        end
                    end
                    default: begin
                        r_state    <= ST_SEARCH;
                        r_locked   <= 1'b0;
                        r_good_cnt <= '0;
                        r_bad_cnt  <= '0;
                    end
                endcase
            end

            // The word that triggers unlock is still in LOCKED here, so its
            // errors are included. clear wins over a same-cycle add.
            if (clear) begin
                r_err_count <= '0;
            end else if (w_count_en) begin
                r_err_count <= w_err_sat;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Optional word counter
    // ------------------------------------------------------------------------
`ifdef LFSR_PRBS_CHK_WORD_CNT_EN
    logic [31:0] r_word_count;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_word_count <= '0;
        end else if (clear) begin
            r_word_count <= '0;
        end else if (w_count_en && (r_word_count != 32'hFFFF_FFFF)) begin
            r_word_count <= r_word_count + 32'd1;
        end
    end

    assign word_count = r_word_count;
`else
    assign word_count = 32'd0;
`endif

    assign err_out   = r_err_out;
    assign err_valid = r_err_valid;
    assign locked    = r_locked;
    assign err_count = r_err_count;

endmodule
`default_nettype wire

// File: tb/tb_lfsr_prbs_chk.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_lfsr_prbs_chk
// Purpose  : Self-checking bench for lfsr_prbs_chk (default parameters).
//            A table of hand-computed vectors built on an all-zero stream
//            (data_in = 8'hFF, inverted) exercises lock, error echo timing,
//            unlock, clear priority and enable gaps. Hand-written sequences
//            then use a PRBS31 model for lock-up, bit flips, gaps, a forced
//            pattern and a mid-lock reset.
// Revision : 1.0 - initial release
// ============================================================================
module tb_lfsr_prbs_chk;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        en;
    logic [7:0]  din;
    logic        clr;
    logic [7:0]  err_out;
    logic        err_valid;
    logic        locked;
    logic [31:0] err_count;
    logic [31:0] word_count;

    int n_vec = 0;
    int n_err = 0;

    lfsr_prbs_chk dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .enable     (en),
        .data_in    (din),
        .clear      (clr),
        .err_out    (err_out),
        .err_valid  (err_valid),
        .locked     (locked),
        .err_count  (err_count),
        .word_count (word_count)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not reach the summary");
        $fatal(1);
    end

    typedef struct packed {
        logic        en;
        logic        clr;
        logic [7:0]  din;
        logic [7:0]  e_err;
        logic        e_vld;
        logic        e_lock;
        logic [31:0] e_cnt;
        logic [31:0] e_wc;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] wc(input int x);
`ifdef LFSR_PRBS_CHK_WORD_CNT_EN
        return 32'(x);
`else
        return 32'd0 & 32'(x);
`endif
    endfunction

    function automatic vec_t mk(input logic e, input logic c, input logic [7:0] d,
                                input logic [7:0] ee, input logic ev, input logic el,
                                input int ec, input int ew);
        vec_t v;
        v.en = e; v.clr = c; v.din = d; v.e_err = ee; v.e_vld = ev;
        v.e_lock = el; v.e_cnt = 32'(ec); v.e_wc = wc(ew);
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // PRBS31 (x^31+x^28+1) Fibonacci generator, MSB first, inverted on the line.
    logic [30:0] gen_s;
    task automatic prbs_next(output logic [7:0] w);
        logic [7:0] t;
        logic       b;
        for (int i = 7; i >= 0; i--) begin
            b     = gen_s[30] ^ gen_s[27];
            t[i]  = b;
            gen_s = {gen_s[29:0], b};
        end
        w = ~t;
    endtask

    initial begin
        logic [7:0]  d;
        logic [31:0] frozen;
        int          lock_at, unl, nz, nv;

        // ---------------- table: all-zero stream, hand-computed ----------
        // 16 clean words from reset -> lock on the 16th
        for (int i = 0; i < 15; i++) tbl.push_back(mk(1, 0, 8'hFF, 8'h00, 1, 0, 0, 0));
        tbl.push_back(mk(1, 0, 8'hFF, 8'h00, 1, 1, 0, 0));
        // single line error on bit 0: echoed 28 and 31 bit-times later (word+4, bits 4 and 1)
        tbl.push_back(mk(1, 0, 8'hFE, 8'h01, 1, 1, 1, 1));
        tbl.push_back(mk(1, 0, 8'hFF, 8'h00, 1, 1, 1, 2));
        tbl.push_back(mk(1, 0, 8'hFF, 8'h00, 1, 1, 1, 3));
        tbl.push_back(mk(1, 0, 8'hFF, 8'h00, 1, 1, 1, 4));
        tbl.push_back(mk(1, 0, 8'hFF, 8'h12, 1, 1, 3, 5));
        // enable gap: err_out holds, err_valid low; clear while idle
        tbl.push_back(mk(0, 0, 8'h00, 8'h12, 0, 1, 3, 5));
        tbl.push_back(mk(0, 1, 8'h00, 8'h12, 0, 1, 0, 0));
        tbl.push_back(mk(1, 0, 8'hFF, 8'h00, 1, 1, 0, 1));
        // four consecutive errored words -> unlock, last one still counted
        tbl.push_back(mk(1, 0, 8'hFE, 8'h01, 1, 1, 1, 2));
        tbl.push_back(mk(1, 0, 8'hFE, 8'h01, 1, 1, 2, 3));
        tbl.push_back(mk(1, 0, 8'hFE, 8'h01, 1, 1, 3, 4));
        tbl.push_back(mk(1, 0, 8'hFE, 8'h01, 1, 0, 4, 5));
        // echoes arrive in SEARCH: counters frozen
        for (int i = 0; i < 4; i++)  tbl.push_back(mk(1, 0, 8'hFF, 8'h12, 1, 0, 4, 5));
        for (int i = 0; i < 15; i++) tbl.push_back(mk(1, 0, 8'hFF, 8'h00, 1, 0, 4, 5));
        tbl.push_back(mk(1, 0, 8'hFF, 8'h00, 1, 1, 4, 5));
        // err_count reaches 5, then clear in the same cycle as an errored word
        tbl.push_back(mk(1, 0, 8'hFE, 8'h01, 1, 1, 5, 6));
        tbl.push_back(mk(1, 1, 8'hFE, 8'h01, 1, 1, 0, 0));
        // history was untouched by clear: both echoes still appear
        tbl.push_back(mk(1, 0, 8'hFF, 8'h00, 1, 1, 0, 1));
        tbl.push_back(mk(1, 0, 8'hFF, 8'h00, 1, 1, 0, 2));
        tbl.push_back(mk(1, 0, 8'hFF, 8'h12, 1, 1, 2, 3));
        tbl.push_back(mk(1, 0, 8'hFF, 8'h12, 1, 1, 4, 4));
        tbl.push_back(mk(1, 0, 8'hFF, 8'h00, 1, 1, 4, 5));

        // ---------------- reset ----------------
        rst_n = 1'b1; en = 1'b0; clr = 1'b0; din = 8'h00;
        #2 rst_n = 1'b0;
        #1;
        check("reset err_out", 32'(err_out), 32'h0);
        check("reset err_valid", 32'(err_valid), 32'h0);
        check("reset locked", 32'(locked), 32'h0);
        check("reset err_count", err_count, 32'h0);
        check("reset word_count", word_count, 32'h0);
        step();
        rst_n = 1'b1;

        // ---------------- apply table ----------------
        for (int i = 0; i < tbl.size(); i++) begin
            en = tbl[i].en; clr = tbl[i].clr; din = tbl[i].din;
            step();
            check($sformatf("vec%0d err_out", i), 32'(err_out), 32'(tbl[i].e_err));
            check($sformatf("vec%0d err_valid", i), 32'(err_valid), 32'(tbl[i].e_vld));
            check($sformatf("vec%0d locked", i), 32'(locked), 32'(tbl[i].e_lock));
            check($sformatf("vec%0d err_count", i), err_count, tbl[i].e_cnt);
            check($sformatf("vec%0d word_count", i), word_count, tbl[i].e_wc);
        end
        clr = 1'b0;

        // ---------------- reset mid-lock ----------------
        rst_n = 1'b0;
        #1;
        check("midreset locked", 32'(locked), 32'h0);
        check("midreset err_count", err_count, 32'h0);
        check("midreset word_count", word_count, 32'h0);
        check("midreset err_valid", 32'(err_valid), 32'h0);
        en = 1'b0;
        step();
        rst_n = 1'b1;

        // ---------------- PRBS lock-up ----------------
        gen_s   = 31'h1234567;
        lock_at = 0;
        en      = 1'b1;
        for (int w = 1; w <= 21 && lock_at == 0; w++) begin
            prbs_next(d); din = d;
            step();
            if (locked) lock_at = w;
        end
        check("prbs lock word in [16,21]", 32'((lock_at >= 16) && (lock_at <= 21)), 32'h1);
        check("prbs err_count after lock", err_count, 32'h0);

        // ---------------- 1000 clean words ----------------
        nz = 0;
        for (int w = 0; w < 1000; w++) begin
            prbs_next(d); din = d;
            step();
            if (err_out != 8'h00 || !err_valid) nz++;
        end
        check("prbs 1000 words errored", 32'(nz), 32'h0);
        check("prbs 1000 err_count", err_count, 32'h0);
        check("prbs 1000 locked", 32'(locked), 32'h1);

        // ---------------- single bit flip ----------------
        prbs_next(d); din = d ^ 8'h01;
        step();
        check("flip err_out", 32'(err_out), 32'h01);
        for (int j = 0; j < 3; j++) begin
            prbs_next(d); din = d;
            step();
            check($sformatf("flip quiet%0d", j), 32'(err_out), 32'h00);
        end
        prbs_next(d); din = d;
        step();
        check("flip echoes", 32'(err_out), 32'h12);
        prbs_next(d); din = d;
        step();
        check("flip err_count", err_count, 32'd3);
        check("flip locked", 32'(locked), 32'h1);

        // ---------------- enable gap with garbage ----------------
        en = 1'b0; nv = 0;
        for (int j = 0; j < 10; j++) begin
            din = 8'($urandom);
            step();
            if (err_valid) nv++;
        end
        check("gap err_valid", 32'(nv), 32'h0);
        check("gap err_count", err_count, 32'd3);
        check("gap locked", 32'(locked), 32'h1);
        en = 1'b1; nz = 0;
        for (int j = 0; j < 5; j++) begin
            prbs_next(d); din = d;
            step();
            if (err_out != 8'h00) nz++;
        end
        check("resume errored words", 32'(nz), 32'h0);
        check("resume err_count", err_count, 32'd3);
        check("resume locked", 32'(locked), 32'h1);

        // ---------------- forced A5 -> unlock, count freezes ----------------
        din = 8'hA5; unl = 0;
        for (int w = 1; w <= 8 && unl == 0; w++) begin
            step();
            if (!locked) unl = w;
        end
        check("a5 unlock word in [4,8]", 32'((unl >= 4) && (unl <= 8)), 32'h1);
        frozen = err_count;
        check("a5 errors counted while locked", 32'(frozen > 32'd3), 32'h1);
        for (int w = 0; w < 6; w++) step();
        check("a5 err_count frozen", err_count, frozen);
        check("a5 still unlocked", 32'(locked), 32'h0);

        en = 1'b0;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
